// File: rtl/alu_muldiv_pkg.sv
// Shared operation codes, fill constant and FSM state encoding for the ALU
// and the multiply/divide unit.
package alu_muldiv_pkg;

    typedef enum logic [4:0] {
        OPNULL   = 5'h00,
        OPMUL    = 5'h08,
        OPMULH   = 5'h09,
        OPMULHSU = 5'h0A,
        OPMULHU  = 5'h0B,
        OPDIV    = 5'h0C,
        OPDIVU   = 5'h0D,
        OPREM    = 5'h0E,
        OPREMU   = 5'h0F
    } op_t;

    // Wide zero; users narrow it with a size cast to their own WIDTH.
    localparam logic [127:0] ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

endpackage

// File: rtl/muldiv_core.sv
// One radix-2 step of an unsigned shift-add multiplier or restoring divider,
// operating on a {hi, lo} register pair.
module muldiv_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opr,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opr} : '0);
        shifted = {hi, lo[WIDTH-1]};
        // Remainder stays below the divisor, so bit WIDTH of diff is the borrow.
        diff    = shifted - {1'b0, opr};
        hi_n    = '0;
        lo_n    = '0;
        if (div) begin
            hi_n = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit: operands are reduced to magnitudes on accept,
// processed one bit per cycle by muldiv_core, and sign-corrected in DONE.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned FAST_MUL = 0
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [4:0]       iControl,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iAbort,
    output logic             oReady,
    output logic             oValid,
    output logic [WIDTH-1:0] oResult
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [4:0]         op_q;
    logic               div_q;
    logic               neg_q;
    logic               neg_r;
    logic               byp_q;
    logic [WIDTH-1:0]   byp_res;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   opr;
    logic [WIDTH-1:0]   hi_n;
    logic [WIDTH-1:0]   lo_n;

    logic               is_mul;
    logic               is_div;
    logic               a_sgn;
    logic               b_sgn;
    logic               known;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_f;
    logic               bypass;
    logic [WIDTH-1:0]   byp_val;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fin_res;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        a_sgn  = 1'b0;
        b_sgn  = 1'b0;
        known  = 1'b1;
        case (iControl)
            OPMUL, OPMULH: begin is_mul = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            OPMULHSU:      begin is_mul = 1'b1; a_sgn = 1'b1; end
            OPMULHU:       is_mul = 1'b1;
            OPDIV, OPREM:  begin is_div = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            OPDIVU, OPREMU: is_div = 1'b1;
            default:       known = 1'b0;
        endcase
        a_neg  = a_sgn & iA[WIDTH-1];
        b_neg  = b_sgn & iB[WIDTH-1];
        a_mag  = a_neg ? -iA : iA;
        b_mag  = b_neg ? -iB : iB;
        prod_f = {{WIDTH{a_neg}}, iA} * {{WIDTH{b_neg}}, iB};
        bypass = ~known | (is_mul & (FAST_MUL != 0)) | (is_div & (iB == '0));
        if (!known)
            byp_val = WIDTH'(ZERO);
        else if (is_mul)
            byp_val = (iControl == OPMUL) ? prod_f[WIDTH-1:0] : prod_f[2*WIDTH-1:WIDTH];
        else if (iControl == OPDIV || iControl == OPDIVU)
            byp_val = '1;
        else
            byp_val = iA;
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .div  (div_q),
        .hi   (hi),
        .lo   (lo),
        .opr  (opr),
        .hi_n (hi_n),
        .lo_n (lo_n)
    );

    always_comb begin
        prod_s = neg_q ? -{hi, lo} : {hi, lo};
        case (op_q)
            OPMUL:                      fin_res = prod_s[WIDTH-1:0];
            OPMULH, OPMULHU, OPMULHSU:  fin_res = prod_s[2*WIDTH-1:WIDTH];
            OPDIV, OPDIVU:              fin_res = neg_q ? -lo : lo;
            OPREM, OPREMU:              fin_res = neg_r ? -hi : hi;
            default:                    fin_res = WIDTH'(ZERO);
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_q    <= OPNULL;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            byp_q   <= 1'b0;
            byp_res <= '0;
            hi      <= '0;
            lo      <= '0;
            opr     <= '0;
            oReady  <= 1'b1;
            oValid  <= 1'b0;
            oResult <= WIDTH'(ZERO);
        end else begin
            oValid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (iStart && !iAbort) begin
                        op_q    <= iControl;
                        div_q   <= is_div;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        byp_q   <= bypass;
                        byp_res <= byp_val;
                        hi      <= '0;
                        lo      <= is_mul ? b_mag : a_mag;
                        opr     <= is_mul ? a_mag : b_mag;
                        oReady  <= 1'b0;
                        if (bypass) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_CALC;
                            cnt   <= CW'(WIDTH - 1);
                        end
                    end
                end
                S_CALC: begin
                    if (iAbort) begin
                        state  <= S_IDLE;
                        cnt    <= '0;
                        oReady <= 1'b1;
                    end else begin
                        hi <= hi_n;
                        lo <= lo_n;
                        if (cnt == '0)
                            state <= S_DONE;
                        else
                            cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    oReady <= 1'b1;
                    if (!iAbort) begin
                        oValid  <= 1'b1;
                        oResult <= byp_q ? byp_res : fin_res;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    oReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width, even, at least 8.
REQ-002 Parameter FAST_MUL, default 0: 0 = iterative multiply; 1 = single-cycle product with registered output.
REQ-003 iCLK  input  1  system clock; all state changes on the rising edge.
REQ-004 iRST  input  1  reset, asynchronous and active-high.
REQ-005 iStart  input  1  request; accepted on an edge where iStart=1 and oReady=1.
REQ-006 iControl  input  5  operation code: OPMUL, OPMULH, OPMULHU, OPMULHSU, OPDIV, OPDIVU, OPREM, OPREMU.
REQ-007 iA  input  WIDTH  operand A, rs1.
REQ-008 iB  input  WIDTH  operand B, rs2.
REQ-009 iAbort  input  1  synchronous cancel of the operation in flight.
REQ-010 oReady  output  1  unit idle; a request may be accepted.
REQ-011 oValid  output  1  one-cycle pulse; oResult is valid.
REQ-012 oResult  output  WIDTH  result; holds its value until the next oValid.

Function
REQ-013 The unit SHALL implement the FSM IDLE -> CALC -> DONE -> IDLE, with oReady=1 only in IDLE.
REQ-014 On acceptance, iControl, iA and iB SHALL be captured, and later input changes SHALL NOT affect the result.
REQ-015 CALC SHALL last exactly WIDTH cycles (one radix-2 step per cycle, counter WIDTH-1 down to 0); oValid therefore rises WIDTH+1 cycles after the acceptance edge.
REQ-016 Bypass: with FAST_MUL=1 for multiply codes, for division by zero, and for unknown codes, the FSM SHALL go IDLE -> DONE, so oValid rises 1 cycle after acceptance.
REQ-017 Multiplication SHALL produce a 2*WIDTH product with operand signedness per op: MUL/MULH signed x signed, MULHU unsigned x unsigned, MULHSU signed A x unsigned B.
REQ-018 MUL SHALL return product[WIDTH-1:0]; all other multiply ops SHALL return product[2*WIDTH-1:WIDTH].
REQ-019 Signed division SHALL divide magnitudes, then negate the quotient if sign(A) differs from sign(B), and negate the remainder if A is negative; the quotient truncates toward zero.
REQ-020 Divide by zero: DIV/DIVU SHALL return all-ones and REM/REMU SHALL return A.
REQ-021 Signed overflow (A = most-negative, B = -1): DIV SHALL return A and REM SHALL return 0 through the normal CALC path.
REQ-022 Unknown iControl SHALL return ZERO.
REQ-023 iStart while busy SHALL be ignored; it is neither queued nor flagged.
REQ-024 iAbort SHALL force IDLE on the next edge with no oValid and oResult unchanged.
REQ-025 iAbort and iStart in the same IDLE cycle: abort SHALL win, and nothing is accepted.
REQ-026 A new request SHALL be accepted in the cycle after DONE, giving a back-to-back period of WIDTH+2 cycles.

Reset
REQ-027 iRST SHALL force IDLE immediately: oReady=1, oValid=0, oResult=ZERO, counter=0, and internal registers cleared.
REQ-028 Reset during CALC SHALL discard the operation, and no oValid SHALL follow reset release.

Structure
REQ-029 The op codes (OPMUL..OPREMU, OPNULL), ZERO and the FSM state enum SHALL live in the shared parameters package, which is also used by the ALU.
REQ-030 The unit SHALL contain one sub-module, muldiv_core: a combinational one-step shift-add/shift-subtract datapath that the FSM instantiates once.
REQ-031 The unit SHALL contain no combinational path from inputs to oResult or oValid.

Verification (WIDTH=32)
REQ-032 MUL A=7, B=0xFFFFFFFD -> oResult 0xFFFFFFEB; oValid exactly 33 cycles after acceptance.
REQ-033 High-half multiplies:
- MULH 0x80000000 x 0x80000000 -> 0x40000000
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF
REQ-034 Signed division, A=0xFFFFFFF9 (-7), B=2: DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU -> 0x7FFFFFFC.
REQ-035 Special cases:
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with oValid 1 cycle after acceptance
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0
REQ-036 Busy/abort handling:
- iStart pulsed at cycle 10 of a DIV -> ignored; exactly one oValid, carrying the original result
- iAbort at cycle 5 -> oReady=1 next cycle, no oValid
REQ-037 Reset handling: iRST asserted mid-CALC, asynchronously between edges -> outputs at reset values immediately; after release, no spurious oValid over 40 cycles.
